// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the 16-bit register-file/ALU datapath.
// Captures one instruction per start handshake and sequences read, execute and write-back.
module alu_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic              err,
  output logic [2:0]        nsel,
  output logic              vsel,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm8
);

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    WR_IMM,
    GET_A,
    GET_B,
    EXEC,
    WR_REG
  } state_t;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] nsel;
    logic       vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] aluop;
    logic [1:0] shift;
  } ctl_t;

  state_t      state, state_nx;
  logic [15:0] ir, ir_nx;
  ctl_t        ctl_q, ctl_nx;

  function automatic logic is_movimm(input logic [15:0] i);
    return (i[15:13] == 3'b110) && (i[12:11] == 2'b10);
  endfunction

  function automatic logic is_movreg(input logic [15:0] i);
    return (i[15:13] == 3'b110) && (i[12:11] == 2'b00);
  endfunction

  function automatic logic is_alu(input logic [15:0] i);
    return i[15:13] == 3'b101;
  endfunction

  assign ir_nx = (state == WAIT && s) ? in : ir;

  always_comb begin
    state_nx = WAIT;
    case (state)
      WAIT:    state_nx = s ? DECODE : WAIT;
      DECODE: begin
        if (is_movimm(ir))
          state_nx = WR_IMM;
        else if (is_alu(ir) && ir[12:11] != 2'b11)
          state_nx = GET_A;
        else if (is_movreg(ir) || is_alu(ir))
          state_nx = GET_B;
        else
          state_nx = WAIT;
      end
      WR_IMM:  state_nx = WAIT;
      GET_A:   state_nx = GET_B;
      GET_B:   state_nx = EXEC;
      EXEC:    state_nx = (is_alu(ir) && ir[12:11] == 2'b01) ? WAIT : WR_REG;
      WR_REG:  state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  // Controls are the Moore decode of the state being entered, so registering
  // them here gives exactly the decode of (state, ir) with no path from s/in.
  always_comb begin
    ctl_nx = '0;
    case (state_nx)
      WAIT:   ctl_nx.w = 1'b1;
      DECODE: ctl_nx.err = ~(is_movimm(ir_nx) | is_movreg(ir_nx) | is_alu(ir_nx));
      WR_IMM: begin
        ctl_nx.nsel  = 3'b001;
        ctl_nx.vsel  = 1'b1;
        ctl_nx.write = 1'b1;
      end
      GET_A: begin
        ctl_nx.nsel  = 3'b001;
        ctl_nx.loada = 1'b1;
      end
      GET_B: begin
        ctl_nx.nsel  = 3'b100;
        ctl_nx.loadb = 1'b1;
      end
      EXEC: begin
        ctl_nx.shift = ir_nx[4:3];
        if (is_movreg(ir_nx)) begin
          ctl_nx.asel  = 1'b1;
          ctl_nx.loadc = 1'b1;
        end else if (ir_nx[12:11] == 2'b01) begin
          ctl_nx.aluop = 2'b01;
          ctl_nx.loads = 1'b1;
        end else begin
          ctl_nx.aluop = ir_nx[12:11];
          ctl_nx.loadc = 1'b1;
        end
      end
      WR_REG: begin
        ctl_nx.nsel  = 3'b010;
        ctl_nx.write = 1'b1;
      end
      default: ctl_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT;
      ir      <= '0;
      ctl_q   <= '0;
      ctl_q.w <= 1'b1;
    end else begin
      state <= state_nx;
      ir    <= ir_nx;
      ctl_q <= ctl_nx;
    end
  end

  assign w      = ctl_q.w;
  assign err    = ctl_q.err;
  assign nsel   = ctl_q.nsel;
  assign vsel   = ctl_q.vsel;
  assign write  = ctl_q.write;
  assign loada  = ctl_q.loada;
  assign loadb  = ctl_q.loadb;
  assign loadc  = ctl_q.loadc;
  assign loads  = ctl_q.loads;
  assign asel   = ctl_q.asel;
  assign ALUop  = ctl_q.aluop;
  assign shift  = ctl_q.shift;
  assign sximm8 = DATA_W'($signed(ir[7:0]));

  // Register-number fields steer the datapath muxes, not this sequencer.
  logic unused_rn;
  assign unused_rn = ^ir[10:8];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random
// instructions compared against a per-instruction control-sequence model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w, err, vsel, write, loada, loadb, loadc, loads, asel;
  logic [2:0]  nsel;
  logic [1:0]  ALUop, shift;
  logic [15:0] sximm8;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_v [0:5];
  int          exp_n;
  logic [15:0] last_instr;

  alu_sequencer #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .s(s), .in(in),
    .w(w), .err(err), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .ALUop(ALUop), .shift(shift), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {w, err, nsel, vsel, write, loada, loadb, loadc, loads, asel, ALUop, shift};

  function automatic logic [15:0] vec(input logic w_, input logic err_, input logic [2:0] ns,
                                      input logic vs, input logic wr, input logic la,
                                      input logic lb, input logic lc, input logic ls,
                                      input logic as, input logic [1:0] op, input logic [1:0] sh);
    return {w_, err_, ns, vs, wr, la, lb, lc, ls, as, op, sh};
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] i);
    logic [7:0] b;
    b = i[7:0];
    return {{8{b[7]}}, b};
  endfunction

  localparam logic [15:0] WAIT_V = 16'h8000;

  // Expected control word for each cycle after acceptance, built from the
  // instruction's class: decode, optional operand reads, execute, write-back.
  task automatic plan(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] op, sh;
    opc = i[15:13];
    op  = i[12:11];
    sh  = i[4:3];
    exp_n = 0;
    if (opc == 3'b110 && op == 2'b10) begin
      exp_v[exp_n++] = '0;
      exp_v[exp_n++] = vec(0, 0, 3'b001, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    end else if (opc == 3'b110 && op == 2'b00) begin
      exp_v[exp_n++] = '0;
      exp_v[exp_n++] = vec(0, 0, 3'b100, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
      exp_v[exp_n++] = vec(0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 1, 2'b00, sh);
      exp_v[exp_n++] = vec(0, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    end else if (opc == 3'b101) begin
      exp_v[exp_n++] = '0;
      if (op != 2'b11)
        exp_v[exp_n++] = vec(0, 0, 3'b001, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
      exp_v[exp_n++] = vec(0, 0, 3'b100, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
      if (op == 2'b01)
        exp_v[exp_n++] = vec(0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 2'b01, sh);
      else begin
        exp_v[exp_n++] = vec(0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, op, sh);
        exp_v[exp_n++] = vec(0, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      end
    end else begin
      exp_v[exp_n++] = vec(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_excl();
    chk("excl", 32'($countones({write, loada, loadb, loadc, loads}) <= 1), 32'd1);
  endtask

  // Accepts one instruction at the next edge and checks every following
  // cycle; with noise set, s and in are toggled while the FSM is busy.
  task automatic run(input logic [15:0] instr, input logic noise);
    @(negedge clk);
    s = 1'b1;
    in = instr;
    plan(instr);
    last_instr = instr;
    @(posedge clk);
    for (int i = 0; i < exp_n; i++) begin
      #1;
      chk("ctl", 32'(obs), 32'(exp_v[i]));
      chk("sximm8", 32'(sximm8), 32'(sx(instr)));
      chk_excl();
      @(negedge clk);
      if (noise && i < exp_n - 1) begin
        s  = 1'($urandom_range(0, 1));
        in = 16'($urandom);
      end else begin
        s  = 1'b0;
        in = 16'($urandom);
      end
      @(posedge clk);
    end
    #1;
    chk("done", 32'(obs), 32'(WAIT_V));
    chk("sximm8_done", 32'(sximm8), 32'(sx(instr)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s  = 1'b0;
      in = 16'($urandom);
      @(posedge clk);
      #1;
      chk("idle", 32'(obs), 32'(WAIT_V));
      chk("idle_sximm8", 32'(sximm8), 32'(sx(last_instr)));
    end
  endtask

  initial begin
    logic [15:0] r;
    int          k;

    reset = 1'b1;
    s = 1'b0;
    in = 16'h0000;
    last_instr = 16'h0000;
    #12;
    chk("reset_ctl", 32'(obs), 32'(WAIT_V));
    chk("reset_sximm8", 32'(sximm8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Reset asserted between edges while WR_IMM is writing.
    @(negedge clk);
    s = 1'b1;
    in = 16'hD2F6;
    @(posedge clk);
    #1;
    chk("rst_decode", 32'(obs), 32'd0);
    @(negedge clk);
    s = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wrimm", 32'(obs), 32'(vec(0, 0, 3'b001, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", 32'(obs), 32'(WAIT_V));
    chk("rst_async_sx", 32'(sximm8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_instr = 16'h0000;
    idle(2);

    run(16'hD2F6, 1'b0);
    chk("movimm_sx", 32'(sximm8), 32'h0000FFF6);
    run(16'hA148, 1'b0);
    run(16'hA9C4, 1'b0);
    run(16'hB8A0, 1'b0);
    run(16'hC0E3, 1'b0);
    run(16'hE000, 1'b0);
    run(16'hA148, 1'b1);
    run(16'hC0F3, 1'b1);
    idle(1);

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 6));
      r = 16'($urandom);
      case (k)
        0: r[15:11] = 5'b11010;
        1: r[15:11] = 5'b11000;
        2, 3, 4, 5: r[15:11] = {3'b101, 2'(k - 2)};
        default: begin
          while ((r[15:13] == 3'b101) || (r[15:13] == 3'b110 && r[11] == 1'b0))
            r = 16'($urandom);
        end
      endcase
      run(r, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        idle(int'($urandom_range(1, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
